upd4990_ctrl: RTL and testbench

UPD4990_CTRL -- requirements
Module: upd4990_ctrl

---
 rtl/upd4990_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_upd4990_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upd4990_ctrl.sv
// upd4990_ctrl: serial controller for the uPD4990 real-time clock.
// Sends 4-bit commands (LSB first, then a strobe pulse) and reads the 48-bit time
// register. All timing is in phases of 8 CLK_EN ticks.
// Build option: define UPD4990_CTRL_AUTOHOLD_EN to send a hold command (0000) after
// each read. Without it the RTC stays in shift mode once a read has finished.

module upd4990_ctrl (
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        CLK_EN,
   input  logic        START_READ,
   input  logic        START_CMD,
   input  logic [3:0]  CMD,
   input  logic        DATA_OUT,
   output logic        CS,
   output logic        DATA_CLK,
   output logic        DATA_IN,
   output logic        STROBE,
   output logic        BUSY,
   output logic        DONE,
   output logic [47:0] TIME
);

   typedef enum logic [2:0] {
      StIdle, StCmdLo, StCmdHi, StStbHi, StStbLo, StRdLo, StRdHi, StFin
   } state_e;

   // Read sub-steps: load command, shift-enable command, then the data bits
   localparam logic [1:0] StepLoad  = 2'd0;
   localparam logic [1:0] StepShift = 2'd1;
   localparam logic [1:0] StepRead  = 2'd2;

   localparam logic [3:0] CmdLoad  = 4'b0011;
   localparam logic [3:0] CmdShift = 4'b0001;

   state_e      state_q, state_d;
   logic [2:0]  tick_q, tick_d;
   logic [1:0]  bit_q, bit_d;
   logic [5:0]  rd_q, rd_d;
   logic [1:0]  step_q, step_d;
   logic [3:0]  cmd_q, cmd_d;
   logic        read_q, read_d;
   logic [47:0] time_q, time_d;

   logic last_tick;
   logic busy;

   assign last_tick = CLK_EN && (tick_q == 3'd7);

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state_q <= StIdle;
         tick_q  <= 3'd0;
         bit_q   <= 2'd0;
         rd_q    <= 6'd0;
         step_q  <= StepLoad;
         cmd_q   <= 4'd0;
         read_q  <= 1'b0;
         time_q  <= 48'd0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         rd_q    <= rd_d;
         step_q  <= step_d;
         cmd_q   <= cmd_d;
         read_q  <= read_d;
         time_q  <= time_d;
      end
   end

   // Next-state: phase sequencing, counters and TIME shift
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      rd_d    = rd_q;
      step_d  = step_q;
      cmd_d   = cmd_q;
      read_d  = read_q;
      time_d  = time_q;

      // Phase timer runs only while a phase is active; wraps to 0 at each boundary
      if (CLK_EN && (state_q != StIdle) && (state_q != StFin)) begin
         tick_d = tick_q + 3'd1;
      end

      unique case (state_q)
         StIdle: begin
            tick_d = 3'd0;
            bit_d  = 2'd0;
            rd_d   = 6'd0;
            step_d = StepLoad;
            // A read wins over a simultaneous command request
            if (START_READ) begin
               read_d  = 1'b1;
               cmd_d   = CmdLoad;
               state_d = StCmdLo;
            end else if (START_CMD) begin
               read_d  = 1'b0;
               cmd_d   = CMD;
               state_d = StCmdLo;
            end
         end
         StCmdLo: begin
            if (last_tick) state_d = StCmdHi;
         end
         StCmdHi: begin
            if (last_tick) begin
               if (bit_q == 2'd3) begin
                  bit_d   = 2'd0;
                  state_d = StStbHi;
               end else begin
                  bit_d   = bit_q + 2'd1;
                  state_d = StCmdLo;
               end
            end
         end
         StStbHi: begin
            if (last_tick) state_d = StStbLo;
         end
         StStbLo: begin
            if (last_tick) begin
               if (read_q && (step_q == StepLoad)) begin
                  cmd_d   = CmdShift;
                  step_d  = StepShift;
                  state_d = StCmdLo;
               end else if (read_q && (step_q == StepShift)) begin
                  step_d  = StepRead;
                  rd_d    = 6'd0;
                  state_d = StRdLo;
               end else begin
                  state_d = StFin;
               end
            end
         end
         StRdLo: begin
            // Sample at the end of the low phase, just before the RTC shifts
            if (last_tick) begin
               time_d  = {DATA_OUT, time_q[47:1]};
               state_d = StRdHi;
            end
         end
         StRdHi: begin
            if (last_tick) begin
               if (rd_q == 6'd47) begin
`ifdef UPD4990_CTRL_AUTOHOLD_EN
                  // Step stays at StepRead, so the strobe after this goes to FIN
                  cmd_d   = 4'b0000;
                  bit_d   = 2'd0;
                  state_d = StCmdLo;
`else
                  state_d = StFin;
`endif
               end else begin
                  rd_d    = rd_q + 6'd1;
                  state_d = StRdLo;
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded from registered state
   always_comb begin
      busy     = (state_q != StIdle);
      BUSY     = busy;
      CS       = busy;
      DATA_CLK = (state_q == StCmdHi) || (state_q == StRdHi);
      STROBE   = (state_q == StStbHi);
      DATA_IN  = 1'b0;
      if ((state_q == StCmdLo) || (state_q == StCmdHi)) begin
         DATA_IN = cmd_q[bit_q];
      end
      DONE     = (state_q == StFin);
      TIME     = time_q;
   end

endmodule

// File: tb/tb_upd4990_ctrl.sv
// tb_upd4990_ctrl: directed bench for upd4990_ctrl with a small uPD4990 shift-register
// model. Honours UPD4990_CTRL_AUTOHOLD_EN for the expected read length.

module tb_upd4990_ctrl;

`ifdef UPD4990_CTRL_AUTOHOLD_EN
   localparam int READ_TICKS  = 1008;
   localparam int READ_PULSES = 60;
   localparam int READ_STBS   = 3;
`else
   localparam int READ_TICKS  = 928;
   localparam int READ_PULSES = 56;
   localparam int READ_STBS   = 2;
`endif

   logic        CLK = 1'b0;
   logic        nRESET = 1'b0;
   logic        CLK_EN = 1'b1;
   logic        START_READ = 1'b0;
   logic        START_CMD = 1'b0;
   logic [3:0]  CMD = 4'd0;
   logic        DATA_OUT;
   logic        CS, DATA_CLK, DATA_IN, STROBE, BUSY, DONE;
   logic [47:0] TIME;

   always #5 CLK = ~CLK;

   upd4990_ctrl dut (
      .CLK        (CLK),
      .nRESET     (nRESET),
      .CLK_EN     (CLK_EN),
      .START_READ (START_READ),
      .START_CMD  (START_CMD),
      .CMD        (CMD),
      .DATA_OUT   (DATA_OUT),
      .CS         (CS),
      .DATA_CLK   (DATA_CLK),
      .DATA_IN    (DATA_IN),
      .STROBE     (STROBE),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .TIME       (TIME)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int ticks = 0;

   // RTC model state and bus monitors
   logic [47:0] rtc_time = 48'd0;
   logic [47:0] rtc_sr = 48'd0;
   logic [3:0]  cmd_sr = 4'd0;
   logic        shift_en = 1'b0;
   logic        dclk_p = 1'b0;
   logic        stb_p = 1'b0;
   logic        last_bit = 1'b0;
   logic        cap[$];
   logic [3:0]  cmd_log[$];
   int dclk_cnt = 0, stb_cnt = 0, dclk_hi = 0, stb_hi = 0;
   int width_err = 0, hold_err = 0, done_cyc = 0;

   assign DATA_OUT = rtc_sr[0];

   // RTC model: latch bits on DATA_CLK rise, decode on STROBE rise; also pulse monitors
   always @(negedge CLK) begin
      if (DATA_CLK && !dclk_p) begin
         cap.push_back(DATA_IN);
         last_bit <= DATA_IN;
         cmd_sr   <= {DATA_IN, cmd_sr[3:1]};
         dclk_cnt <= dclk_cnt + 1;
         if (shift_en) rtc_sr <= rtc_sr >> 1;
      end
      if (DATA_CLK && dclk_p && (DATA_IN !== last_bit)) hold_err <= hold_err + 1;
      if (DATA_CLK) dclk_hi <= dclk_hi + 1;
      else if (dclk_p) begin
         if (dclk_hi != 8) width_err <= width_err + 1;
         dclk_hi <= 0;
      end
      if (STROBE && !stb_p) begin
         cmd_log.push_back(cmd_sr);
         stb_cnt <= stb_cnt + 1;
         case (cmd_sr)
            4'b0011: begin rtc_sr <= rtc_time; shift_en <= 1'b0; end
            4'b0001: shift_en <= 1'b1;
            4'b0000: shift_en <= 1'b0;
            default: ;
         endcase
      end
      if (STROBE) stb_hi <= stb_hi + 1;
      else if (stb_p) begin
         if (stb_hi != 8) width_err <= width_err + 1;
         stb_hi <= 0;
      end
      if (DONE) done_cyc <= done_cyc + 1;
      dclk_p <= DATA_CLK;
      stb_p  <= STROBE;
   end

   // One CLK edge; counts it as a tick if the DUT was busy and enabled going in
   task automatic tick_edge();
      logic b, e;
      b = BUSY;
      e = CLK_EN;
      @(posedge CLK);
      #1;
      if (b && e) ticks++;
   endtask

   task automatic start_seq(input logic rd, input logic cm, input logic [3:0] c);
      START_READ = rd;
      START_CMD  = cm;
      CMD        = c;
      ticks      = 0;
      tick_edge();
      START_READ = 1'b0;
      START_CMD  = 1'b0;
      CMD        = 4'd0;
   endtask

   task automatic wait_done(input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick_edge();
         if (DONE) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      nRESET = 1'b0;
      tick_edge();
      tick_edge();
      tests_run++;
      if ({CS, DATA_CLK, DATA_IN, STROBE, BUSY, DONE} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %b expected 000000",
                  {CS, DATA_CLK, DATA_IN, STROBE, BUSY, DONE});
      end
      tests_run++;
      if (TIME !== 48'd0) begin
         tests_failed++;
         $display("FAIL reset_time: got %h expected 0", TIME);
      end
      nRESET = 1'b1;
      tick_edge();
   endtask

   task automatic test_read();
      logic ok;
      int l0, d0, k0;
      rtc_time = 48'h19_C_2_31_23_59_58;
      l0 = cmd_log.size();
      d0 = dclk_cnt;
      k0 = done_cyc;
      start_seq(1'b1, 1'b0, 4'd0);
      tests_run++;
      if (BUSY !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_busy_rise: got %b expected 1", BUSY);
      end
      wait_done(2000, ok);
      tests_run++;
      if (!ok || ticks != READ_TICKS) begin
         tests_failed++;
         $display("FAIL read_ticks: got %0d (done=%b) expected %0d", ticks, ok, READ_TICKS);
      end
      tests_run++;
      if (TIME !== 48'h19_C_2_31_23_59_58) begin
         tests_failed++;
         $display("FAIL read_time: got %h expected 19c231235958", TIME);
      end
      tests_run++;
      if (cmd_log[l0] !== 4'b0011 || cmd_log[l0+1] !== 4'b0001) begin
         tests_failed++;
         $display("FAIL read_cmds: got %b %b expected 0011 0001", cmd_log[l0], cmd_log[l0+1]);
      end
      tick_edge();
      tick_edge();
      tests_run++;
      if ({DONE, BUSY, CS} !== 3'b000 || done_cyc - k0 != 1) begin
         tests_failed++;
         $display("FAIL read_end: got done/busy/cs %b done_cycles %0d expected 000 1",
                  {DONE, BUSY, CS}, done_cyc - k0);
      end
      tests_run++;
      if (dclk_cnt - d0 != READ_PULSES) begin
         tests_failed++;
         $display("FAIL read_pulses: got %0d expected %0d", dclk_cnt - d0, READ_PULSES);
      end
   endtask

   task automatic test_cmd();
      logic ok;
      logic [3:0] got;
      logic [47:0] t0;
      int c0, d0, s0, w0, h0;
      t0 = TIME;
      c0 = cap.size();
      d0 = dclk_cnt;
      s0 = stb_cnt;
      w0 = width_err;
      h0 = hold_err;
      start_seq(1'b0, 1'b1, 4'b1100);
      wait_done(200, ok);
      tests_run++;
      if (!ok || ticks != 80) begin
         tests_failed++;
         $display("FAIL cmd_ticks: got %0d (done=%b) expected 80", ticks, ok);
      end
      tick_edge();
      tick_edge();
      got = 4'd0;
      for (int i = 0; i < 4; i++) if (cap.size() > c0 + i) got[i] = cap[c0+i];
      tests_run++;
      if (got !== 4'b1100 || cap.size() - c0 != 4) begin
         tests_failed++;
         $display("FAIL cmd_bits: got %b (%0d bits) expected 1100 (4 bits)", got, cap.size() - c0);
      end
      tests_run++;
      if (dclk_cnt - d0 != 4 || stb_cnt - s0 != 1) begin
         tests_failed++;
         $display("FAIL cmd_pulses: got dclk %0d stb %0d expected 4 1", dclk_cnt - d0, stb_cnt - s0);
      end
      tests_run++;
      if (width_err - w0 != 0 || hold_err - h0 != 0) begin
         tests_failed++;
         $display("FAIL cmd_widths: got width errs %0d hold errs %0d expected 0 0",
                  width_err - w0, hold_err - h0);
      end
      tests_run++;
      if (TIME !== t0) begin
         tests_failed++;
         $display("FAIL cmd_time_kept: got %h expected %h", TIME, t0);
      end
   endtask

   task automatic test_cmd_slow();
      logic ok;
      logic [3:0] got;
      int c0;
      c0 = cap.size();
      start_seq(1'b0, 1'b1, 4'b0101);
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         CLK_EN = (i % 3 == 0);
         tick_edge();
         if (DONE) ok = 1'b1;
      end
      CLK_EN = 1'b1;
      tests_run++;
      if (!ok || ticks != 80) begin
         tests_failed++;
         $display("FAIL slow_ticks: got %0d (done=%b) expected 80", ticks, ok);
      end
      tick_edge();
      tick_edge();
      got = 4'd0;
      for (int i = 0; i < 4; i++) if (cap.size() > c0 + i) got[i] = cap[c0+i];
      tests_run++;
      if (got !== 4'b0101) begin
         tests_failed++;
         $display("FAIL slow_bits: got %b expected 0101", got);
      end
   endtask

   task automatic test_both();
      logic ok;
      logic [3:0] got;
      int c0, l0;
      rtc_time = 48'h20_1_3_01_00_00_01;
      c0 = cap.size();
      l0 = cmd_log.size();
      start_seq(1'b1, 1'b1, 4'b0100);
      wait_done(2000, ok);
      tests_run++;
      if (!ok || ticks != READ_TICKS) begin
         tests_failed++;
         $display("FAIL both_ticks: got %0d (done=%b) expected %0d", ticks, ok, READ_TICKS);
      end
      got = 4'd0;
      for (int i = 0; i < 4; i++) got[i] = cap[c0+i];
      tests_run++;
      if (got !== 4'b0011 || cmd_log[l0] !== 4'b0011) begin
         tests_failed++;
         $display("FAIL both_first_cmd: got bits %b strobed %b expected 0011 0011",
                  got, cmd_log[l0]);
      end
      tests_run++;
      if (TIME !== 48'h20_1_3_01_00_00_01) begin
         tests_failed++;
         $display("FAIL both_time: got %h expected 201301000001", TIME);
      end
      tick_edge();
   endtask

   task automatic test_back_to_back();
      logic ok, fired;
      int l0, k0;
      rtc_time = 48'h21_6_5_15_12_34_56;
      l0 = cmd_log.size();
      k0 = done_cyc;
      fired = 1'b0;
      start_seq(1'b1, 1'b0, 4'd0);
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (ticks == 40 && !fired) begin
            START_CMD = 1'b1;
            CMD = 4'b1111;
            fired = 1'b1;
         end
         tick_edge();
         START_CMD = 1'b0;
         if (DONE) ok = 1'b1;
      end
      tests_run++;
      if (!ok || ticks != READ_TICKS) begin
         tests_failed++;
         $display("FAIL ignore_ticks: got %0d (done=%b) expected %0d", ticks, ok, READ_TICKS);
      end
      tests_run++;
      if (TIME !== 48'h21_6_5_15_12_34_56) begin
         tests_failed++;
         $display("FAIL ignore_time: got %h expected 216515123456", TIME);
      end
      repeat (10) tick_edge();
      tests_run++;
      if (done_cyc - k0 != 1 || cmd_log.size() - l0 != READ_STBS || BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL ignore_once: got done %0d strobes %0d busy %b expected 1 %0d 0",
                  done_cyc - k0, cmd_log.size() - l0, BUSY, READ_STBS);
      end
   endtask

   task automatic test_midreset();
      logic ok;
      int k0;
      rtc_time = 48'h19_C_2_31_23_59_58;
      k0 = done_cyc;
      start_seq(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 2000 && ticks < 500; i++) tick_edge();
      nRESET = 1'b0;
      tick_edge();
      tests_run++;
      if ({CS, DATA_CLK, DATA_IN, STROBE, BUSY, DONE} !== 6'b0 || TIME !== 48'd0) begin
         tests_failed++;
         $display("FAIL midreset_clear: got outs %b time %h expected 000000 0",
                  {CS, DATA_CLK, DATA_IN, STROBE, BUSY, DONE}, TIME);
      end
      nRESET = 1'b1;
      repeat (20) tick_edge();
      tests_run++;
      if (done_cyc != k0 || BUSY !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset_nodone: got done %0d busy %b expected 0 0", done_cyc - k0, BUSY);
      end
      start_seq(1'b1, 1'b0, 4'd0);
      wait_done(2000, ok);
      tests_run++;
      if (!ok || ticks != READ_TICKS || TIME !== 48'h19_C_2_31_23_59_58) begin
         tests_failed++;
         $display("FAIL midreset_reread: got ticks %0d time %h expected %0d 19c231235958",
                  ticks, TIME, READ_TICKS);
      end
      tick_edge();
   endtask

   task automatic test_freeze();
      logic ok;
      logic [53:0] snap;
      int frz;
      rtc_time = 48'h18_7_1_04_09_08_07;
      frz = 0;
      start_seq(1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 2000 && ticks < 300; i++) tick_edge();
      CLK_EN = 1'b0;
      snap = {CS, DATA_CLK, DATA_IN, STROBE, BUSY, DONE, TIME};
      for (int i = 0; i < 100; i++) begin
         tick_edge();
         if ({CS, DATA_CLK, DATA_IN, STROBE, BUSY, DONE, TIME} !== snap) frz++;
      end
      CLK_EN = 1'b1;
      tests_run++;
      if (frz != 0 || snap[49] !== 1'b1) begin
         tests_failed++;
         $display("FAIL freeze_hold: got %0d changed cycles busy %b expected 0 1", frz, snap[49]);
      end
      wait_done(2000, ok);
      tests_run++;
      if (!ok || ticks != READ_TICKS) begin
         tests_failed++;
         $display("FAIL freeze_ticks: got %0d (done=%b) expected %0d", ticks, ok, READ_TICKS);
      end
      tests_run++;
      if (TIME !== 48'h18_7_1_04_09_08_07) begin
         tests_failed++;
         $display("FAIL freeze_time: got %h expected 187104090807", TIME);
      end
      tick_edge();
   endtask

   initial begin
      test_reset();
      test_read();
      test_cmd();
      test_cmd_slow();
      test_both();
      test_back_to_back();
      test_midreset();
      test_freeze();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
